// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed seven-segment output stage. A three-digit code set
// (hundreds/tens/units) is captured on an in_valid pulse and scanned onto one
// shared segment bus with one-hot digit enables. An optional blank gap follows
// every digit slot to suppress ghosting. The display returns to blank after a
// configurable number of frames with no new data.
//
// New data arriving mid-frame is parked in a shadow set and only promoted at
// the frame boundary, so a frame never mixes old and new digits.
//
// Parameters:
//   SCAN_DIV       cycles each digit is driven per frame (>= 1)
//   DEAD_CYC       blank cycles after each digit slot (0 = no gap)
//   TIMEOUT_FRAMES frames shown without new data before blanking (0 = never)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   in_valid in   one-cycle pulse, segment inputs valid
//   seg_100  in   [6:0] hundreds code, abcdefg, active-high
//   seg_10   in   [6:0] tens code
//   seg_1    in   [6:0] units code
//   seg_out  out  [6:0] shared segment bus, registered
//   dig_en   out  [2:0] one-hot digit enable, registered ([2]=hundreds)
//   active   out  high whenever the scanner is not idle, registered
//
// Build option:
//   SEG_LZB_EN  when defined, leading zeros (code 7'b1111110) in the hundreds
//               slot, and in the tens slot when hundreds is also zero, are
//               blanked. Slot timing is not affected.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int SCAN_DIV       = 4,
    parameter int DEAD_CYC       = 1,
    parameter int TIMEOUT_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [6:0] seg_100,
    input  logic [6:0] seg_10,
    input  logic [6:0] seg_1,
    output logic [6:0] seg_out,
    output logic [2:0] dig_en,
    output logic       active
);

    // One counter serves both ON and GAP slots, so size it for the longer one.
    localparam int CC_SPAN = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
    localparam int CC_W    = (CC_SPAN > 1) ? $clog2(CC_SPAN) : 1;
    localparam int FC_W    = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

    localparam logic [CC_W-1:0] ON_LAST  = CC_W'(SCAN_DIV - 1);
    localparam logic [CC_W-1:0] GAP_LAST = CC_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    localparam logic [FC_W:0]   TO_LIM   = (FC_W + 1)'(TIMEOUT_FRAMES);
    localparam logic [FC_W:0]   FC_ONE   = (FC_W + 1)'(1);
    localparam logic [FC_W-1:0] FC_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Code sets are indexed by digit position: [0]=hundreds, [1]=tens, [2]=units.
    logic [2:0][6:0] seg_in;
    assign seg_in = {seg_1, seg_10, seg_100};

    state_t          state,  state_nxt;
    logic [1:0]      dix,    dix_nxt;
    logic [CC_W-1:0] cc,     cc_nxt;
    logic [FC_W-1:0] fc,     fc_nxt;
    logic            pend,   pend_nxt;
    logic [2:0][6:0] act,    act_nxt;
    logic [2:0][6:0] sh,     sh_nxt;
    logic            boundary;

    logic [6:0]      seg_nxt;
    logic [2:0]      dig_nxt;
    logic            active_nxt;
    logic            blank;

    function automatic logic [6:0] slot_code(input logic [1:0] d, input logic [2:0][6:0] codes);
        case (d)
            2'd0:    return codes[0];
            2'd1:    return codes[1];
            default: return codes[2];
        endcase
    endfunction

    function automatic logic [2:0] slot_enable(input logic [1:0] d);
        case (d)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

`ifdef SEG_LZB_EN
    localparam logic [6:0] SEG_ZERO = 7'b1111110;

    function automatic logic lzb_blank(input logic [1:0] d, input logic [2:0][6:0] codes);
        case (d)
            2'd0:    return (codes[0] == SEG_ZERO);
            2'd1:    return (codes[0] == SEG_ZERO) && (codes[1] == SEG_ZERO);
            default: return 1'b0;
        endcase
    endfunction

    assign blank = lzb_blank(dix_nxt, act_nxt);
`else
    assign blank = 1'b0;
`endif

    // State and output registers. Outputs are registered from the next-state
    // decode so the first digit appears on the cycle after the capture pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dix     <= '0;
            cc      <= '0;
            fc      <= '0;
            pend    <= 1'b0;
            act     <= '0;
            sh      <= '0;
            seg_out <= '0;
            dig_en  <= '0;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            dix     <= dix_nxt;
            cc      <= cc_nxt;
            fc      <= fc_nxt;
            pend    <= pend_nxt;
            act     <= act_nxt;
            sh      <= sh_nxt;
            seg_out <= seg_nxt;
            dig_en  <= dig_nxt;
            active  <= active_nxt;
        end
    end

    // Next-state decode: slot sequencing, frame boundary and data capture.
    always_comb begin
        state_nxt = state;
        dix_nxt   = dix;
        cc_nxt    = cc;
        fc_nxt    = fc;
        pend_nxt  = pend;
        act_nxt   = act;
        sh_nxt    = sh;
        boundary  = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    act_nxt   = seg_in;
                    pend_nxt  = 1'b0;
                    fc_nxt    = '0;
                    dix_nxt   = '0;
                    cc_nxt    = '0;
                    state_nxt = ON;
                end
            end
            ON: begin
                if (cc == ON_LAST) begin
                    cc_nxt = '0;
                    if (DEAD_CYC != 0) begin
                        state_nxt = GAP;
                    end else if (dix == 2'd2) begin
                        boundary = 1'b1;
                    end else begin
                        dix_nxt = dix + 2'd1;
                    end
                end else begin
                    cc_nxt = cc + 1'b1;
                end
            end
            GAP: begin
                if (cc == GAP_LAST) begin
                    cc_nxt = '0;
                    if (dix == 2'd2) begin
                        boundary = 1'b1;
                    end else begin
                        dix_nxt   = dix + 2'd1;
                        state_nxt = ON;
                    end
                end else begin
                    cc_nxt = cc + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (boundary) begin
            // Last cycle of a frame: fresh input beats parked shadow data,
            // which beats the idle timeout.
            dix_nxt   = '0;
            state_nxt = ON;
            if (in_valid) begin
                act_nxt  = seg_in;
                pend_nxt = 1'b0;
                fc_nxt   = '0;
            end else if (pend) begin
                act_nxt  = sh;
                pend_nxt = 1'b0;
                fc_nxt   = '0;
            end else if ((TIMEOUT_FRAMES != 0) && (({1'b0, fc} + FC_ONE) == TO_LIM)) begin
                state_nxt = IDLE;
            end else if (fc != FC_MAX) begin
                fc_nxt = fc + 1'b1;
            end
        end else if ((state != IDLE) && in_valid) begin
            sh_nxt   = seg_in;
            pend_nxt = 1'b1;
        end
    end

    // Output decode from the next state; blank whenever no digit is enabled.
    always_comb begin
        seg_nxt    = '0;
        dig_nxt    = '0;
        active_nxt = (state_nxt != IDLE);
        if ((state_nxt == ON) && !blank) begin
            dig_nxt = slot_enable(dix_nxt);
            seg_nxt = slot_code(dix_nxt, act_nxt);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Testbench for seg_scan_driver with default parameters. A reference model
// tracks the frame as a cycle position and derives the expected slot, digit
// enable and segment code arithmetically; it queues one expected output per
// clock and a separate monitor pops and compares on the falling edge.
// Directed scenarios (reset, "234", mid-frame update, timeout, async reset,
// "007") are followed by randomized traffic with resets and idle stretches.
// Honors SEG_LZB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int SD    = 4;
    localparam int DC    = 1;
    localparam int TO    = 16;
    localparam int SLOT  = SD + DC;
    localparam int FRAME = 3 * SLOT;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] seg_100  = '0;
    logic [6:0] seg_10   = '0;
    logic [6:0] seg_1    = '0;
    logic [6:0] seg_out;
    logic [2:0] dig_en;
    logic       active;

    seg_scan_driver #(
        .SCAN_DIV       (SD),
        .DEAD_CYC       (DC),
        .TIMEOUT_FRAMES (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .seg_100  (seg_100),
        .seg_10   (seg_10),
        .seg_1    (seg_1),
        .seg_out  (seg_out),
        .dig_en   (dig_en),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] dig;
        logic [6:0] seg;
        logic       act;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: whether a frame is running, position in frame,
    // shown and parked code sets, pending flag, frames shown without news.
    bit         m_on;
    bit         m_pend;
    int         m_pos;
    int         m_frames;
    logic [6:0] m_act[3];
    logic [6:0] m_sh[3];

    function automatic obs_t model_view();
        obs_t o;
        int   slot;
        int   w;
        bit   blank;
        o     = '0;
        blank = 1'b0;
        if (m_on) begin
            o.act = 1'b1;
            slot  = m_pos / SLOT;
            w     = m_pos % SLOT;
            if (w < SD) begin
`ifdef SEG_LZB_EN
                if (slot == 0 && m_act[0] == 7'b1111110) blank = 1'b1;
                if (slot == 1 && m_act[0] == 7'b1111110 && m_act[1] == 7'b1111110) blank = 1'b1;
`endif
                if (!blank) begin
                    o.dig = 3'(4 >> slot);
                    o.seg = m_act[slot];
                end
            end
        end
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got dig=%b seg=%b act=%b, want dig=%b seg=%b act=%b",
                     name, $time, got.dig, got.seg, got.act, want.dig, want.seg, want.act);
        end
    endtask

    // Reference model: one expected output per clock, flushed on reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_on     = 1'b0;
                m_pend   = 1'b0;
                m_pos    = 0;
                m_frames = 0;
                for (int i = 0; i < 3; i++) begin
                    m_act[i] = '0;
                    m_sh[i]  = '0;
                end
                exp_q.delete();
                exp_q.push_back('0);
            end else begin
                if (!m_on) begin
                    if (in_valid) begin
                        m_on     = 1'b1;
                        m_pos    = 0;
                        m_act[0] = seg_100; m_act[1] = seg_10; m_act[2] = seg_1;
                        m_pend   = 1'b0;
                        m_frames = 0;
                    end
                end else if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    if (in_valid) begin
                        m_act[0] = seg_100; m_act[1] = seg_10; m_act[2] = seg_1;
                        m_pend   = 1'b0;
                        m_frames = 0;
                    end else if (m_pend) begin
                        m_act    = m_sh;
                        m_pend   = 1'b0;
                        m_frames = 0;
                    end else if (TO != 0 && m_frames + 1 == TO) begin
                        m_on = 1'b0;
                    end else begin
                        m_frames++;
                    end
                end else begin
                    if (in_valid) begin
                        m_sh[0] = seg_100; m_sh[1] = seg_10; m_sh[2] = seg_1;
                        m_pend  = 1'b1;
                    end
                    m_pos++;
                end
                exp_q.push_back(model_view());
            end
        end
    end

    // Monitor: compare the DUT against the oldest expectation mid-cycle.
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{dig: dig_en, seg: seg_out, act: active};
                check_obs("scoreboard", g, e);
            end
        end
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        seg_100  = h;
        seg_10   = t;
        seg_1    = u;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic expect_now(input string name, input logic [2:0] d, input logic [6:0] s, input logic a);
        obs_t w;
        obs_t g;
        w = '{dig: d, seg: s, act: a};
        g = '{dig: dig_en, seg: seg_out, act: active};
        check_obs(name, g, w);
    endtask

    function automatic logic [6:0] rnd_code();
        logic [6:0] c;
        if ($urandom_range(0, 2) == 0) c = 7'b1111110;
        else c = 7'($urandom);
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        // Reset held, then 45 idle cycles with no stimulus.
        tick(5);
        expect_now("reset_state", 3'b000, 7'b0, 1'b0);
        rst_n = 1'b1;
        tick(45);
        expect_now("idle_no_stim", 3'b000, 7'b0, 1'b0);

        // "234" then "567" arriving at t+7.
        send(7'b1101101, 7'b1111001, 7'b0110011);
        expect_now("t1_hundreds", 3'b100, 7'b1101101, 1'b1);
        tick(4);
        expect_now("t5_gap", 3'b000, 7'b0, 1'b1);
        tick(2);
        send(7'b1011011, 7'b1011111, 7'b1110000);
        expect_now("t8_tens_old", 3'b010, 7'b1111001, 1'b1);
        tick(2);
        expect_now("t10_gap", 3'b000, 7'b0, 1'b1);
        tick(2);
        expect_now("t12_units_old", 3'b001, 7'b0110011, 1'b1);
        tick(3);
        expect_now("t15_gap", 3'b000, 7'b0, 1'b1);
        tick(1);
        expect_now("t16_new_hundreds", 3'b100, 7'b1011011, 1'b1);

        // Timeout: 16 frames from t+16, blank from t+256.
        tick(239);
        expect_now("last_frame_gap", 3'b000, 7'b0, 1'b1);
        tick(1);
        expect_now("timeout_idle", 3'b000, 7'b0, 1'b0);
        tick(9);
        send(7'b1101101, 7'b1111001, 7'b0110011);
        expect_now("restart_after_timeout", 3'b100, 7'b1101101, 1'b1);

        // Asynchronous reset mid-frame with in_valid pulsed during reset.
        tick(7);
        expect_now("pre_reset_tens", 3'b010, 7'b1111001, 1'b1);
        rst_n = 1'b0;
        #1;
        expect_now("async_reset_clears", 3'b000, 7'b0, 1'b0);
        seg_100  = 7'b0110000;
        seg_10   = 7'b0110000;
        seg_1    = 7'b0110000;
        in_valid = 1'b1;
        tick(2);
        in_valid = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(10);
        expect_now("idle_after_reset", 3'b000, 7'b0, 1'b0);

        // "007" leading-zero handling.
        send(7'b1111110, 7'b1111110, 7'b1110000);
`ifdef SEG_LZB_EN
        expect_now("lz_hundreds", 3'b000, 7'b0, 1'b1);
        tick(5);
        expect_now("lz_tens", 3'b000, 7'b0, 1'b1);
`else
        expect_now("lz_hundreds", 3'b100, 7'b1111110, 1'b1);
        tick(5);
        expect_now("lz_tens", 3'b010, 7'b1111110, 1'b1);
`endif
        tick(5);
        expect_now("lz_units", 3'b001, 7'b1110000, 1'b1);

        // Randomized traffic: sparse pulses, occasional resets and long quiet
        // stretches that let the timeout expire.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 12) begin
                seg_100  = rnd_code();
                seg_10   = rnd_code();
                seg_1    = rnd_code();
                in_valid = 1'b1;
                tick(1);
                in_valid = 1'b0;
            end else if (r == 199) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
                tick(1);
            end else if (r == 198) begin
                tick(300);
            end else begin
                tick(1);
            end
        end

        in_valid = 1'b0;
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
